ahb_lite_master_bridge: RTL

//  Converts single core data-memory requests (load/store, funct3-sized) into AHB-Lite single transfers.

---
 rtl/ahb_lite_master_bridge_pkg.sv | 80 ++++++++
 rtl/ahb_lite_master_bridge_lane_align.sv | 53 +++++
 rtl/ahb_lite_master_bridge.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_bridge_pkg.sv
// ahb_lite_master_bridge_pkg
//  Shared types for the core-to-AHB-Lite data bridge: AHB transfer/size
//  encodings, RISC-V load/store funct3 encodings, bridge FSM states, the
//  latched request struct, and small decode helpers.
package ahb_lite_master_bridge_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_ld_i_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3_s_t;

  typedef enum logic [2:0] {
    BR_IDLE,
    BR_ADDR,
    BR_DATA,
    BR_ERR,
    BR_DONE
  } bridge_state_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  // Request captured at acceptance; the address itself lives in haddr_q.
  typedef struct packed {
    logic              is_wr;
    logic [2:0]        funct3;
    logic [1:0]        lane;
    logic [WORD_W-1:0] wdata;
  } bridge_req_t;

  function automatic logic f3_supported(input logic is_wr, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_wr) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // size uses the low two funct3 bits: 0 byte, 1 half, 2 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      2'd1:    mis = lo[0];
      2'd2:    mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ahb_lite_master_bridge_lane_align.sv
// mem_lane_align
//  Combinational byte-lane steering between the core and a 32-bit AHB bus.
//  Ports:
//   funct3  in  load/store size+sign encoding
//   lane    in  byte address offset addr[1:0]
//   st_data in  right-aligned store data
//   hrdata  in  raw AHB read data
//   hwdata  out store data replicated across all lanes of its size
//   ld_data out selected load lanes, sign/zero extended (0 for bad funct3)
module mem_lane_align
  import ahb_lite_master_bridge_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] st_data,
  input  logic [WORD_W-1:0] hrdata,
  output logic [WORD_W-1:0] hwdata,
  output logic [WORD_W-1:0] ld_data
);

  localparam int NUM_LANES = WORD_W / 8;

  logic [NUM_LANES-1:0][7:0] wr_bytes;
  logic [NUM_LANES-1:0][7:0] rd_bytes;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;

  // Replication means the slave picks the right lane without knowing
  // the offset; each lane takes byte 0, the matching half byte, or its own.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_bytes[i] = (funct3[1:0] == 2'b00) ? st_data[7:0] :
                         (funct3[1:0] == 2'b01) ? st_data[8*(i%2) +: 8] :
                                                  st_data[8*i +: 8];
  end
  assign hwdata = wr_bytes;

  assign rd_bytes = hrdata;
  assign ld_byte  = rd_bytes[lane];
  assign ld_half  = lane[1] ? hrdata[31:16] : hrdata[15:0];

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_LB:   ld_data = {{(WORD_W-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(WORD_W-16){ld_half[15]}}, ld_half};
      F3_LW:   ld_data = hrdata;
      F3_LBU:  ld_data = {{(WORD_W-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data = {{(WORD_W-16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// ahb_lite_master_bridge
//  Turns one core load/store at a time into a single AHB-Lite transfer.
//  Misaligned and unsupported-size requests complete locally without bus
//  traffic; bus errors come back as mem_fault.
//  Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_ren/mem_wen           level requests, held until mem_done (store wins)
//   mem_addr/wdata/funct3     request payload
//   mem_rdata/done/fault/misaligned  one-cycle completion report
//   haddr/hwrite/hsize/htrans/hwdata AHB master outputs (all registered)
//   hrdata/hready/hresp       AHB slave responses
module ahb_lite_master_bridge
  import ahb_lite_master_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // must equal WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_fault,
  output logic              mem_misaligned,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [1:0]        htrans,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  bridge_state_t     state_q, state_d;
  bridge_req_t       req_q, req_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  hsize_t            hsize_q, hsize_d;
  htrans_t           htrans_q, htrans_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;
  logic              mem_fault_q, mem_fault_d;
  logic              mem_mis_q, mem_mis_d;

  logic [WORD_W-1:0] st_lanes;
  logic [WORD_W-1:0] ld_ext;

  mem_lane_align u_align (
    .funct3  (req_q.funct3),
    .lane    (req_q.lane),
    .st_data (req_q.wdata),
    .hrdata  (hrdata),
    .hwdata  (st_lanes),
    .ld_data (ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    // Completion outputs are only ever high for the single BR_DONE cycle.
    mem_rdata_d = '0;
    mem_done_d  = 1'b0;
    mem_fault_d = 1'b0;
    mem_mis_d   = 1'b0;

    case (state_q)
      BR_IDLE: begin
        if (mem_wen || mem_ren) begin
          req_d.is_wr  = mem_wen;
          req_d.funct3 = mem_funct3;
          req_d.lane   = mem_addr[1:0];
          req_d.wdata  = mem_wdata;
          if (!f3_supported(mem_wen, mem_funct3)) begin
            state_d     = BR_DONE;
            mem_done_d  = 1'b1;
            mem_fault_d = 1'b1;
          end else if (is_misaligned(mem_funct3[1:0], mem_addr[1:0])) begin
            state_d    = BR_DONE;
            mem_done_d = 1'b1;
            mem_mis_d  = 1'b1;
          end else begin
            state_d  = BR_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = mem_addr;
            hwrite_d = mem_wen;
            hsize_d  = hsize_t'({1'b0, mem_funct3[1:0]});
          end
        end
      end

      BR_ADDR: begin
        if (hready) begin
          state_d  = BR_DATA;
          htrans_d = HTRANS_IDLE;
          hwdata_d = req_q.is_wr ? st_lanes : '0;
        end
      end

      BR_DATA: begin
        if (hresp) begin
          // hready with hresp in the first cycle is a slave protocol slip;
          // still report it as a fault rather than hang.
          if (hready) begin
            state_d     = BR_DONE;
            mem_done_d  = 1'b1;
            mem_fault_d = 1'b1;
          end else begin
            state_d = BR_ERR;
          end
        end else if (hready) begin
          state_d     = BR_DONE;
          mem_done_d  = 1'b1;
          mem_rdata_d = req_q.is_wr ? '0 : ld_ext;
        end
      end

      BR_ERR: begin
        if (hready) begin
          state_d     = BR_DONE;
          mem_done_d  = 1'b1;
          mem_fault_d = 1'b1;
        end
      end

      BR_DONE: begin
        // Requests are deliberately not looked at here so the still-held
        // request that just finished is not issued twice.
        state_d  = BR_IDLE;
        haddr_d  = '0;
        hwrite_d = 1'b0;
        hsize_d  = HSIZE_BYTE;
        hwdata_d = '0;
      end

      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BR_IDLE;
      req_q       <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= HSIZE_BYTE;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      mem_fault_q <= 1'b0;
      mem_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      mem_fault_q <= mem_fault_d;
      mem_mis_q   <= mem_mis_d;
    end
  end

  assign haddr          = haddr_q;
  assign hwrite         = hwrite_q;
  assign hsize          = hsize_q;
  assign htrans         = htrans_q;
  assign hwdata         = hwdata_q;
  assign mem_rdata      = mem_rdata_q;
  assign mem_done       = mem_done_q;
  assign mem_fault      = mem_fault_q;
  assign mem_misaligned = mem_mis_q;

endmodule
